// File: rtl/ex_mdu_if.sv
// Request/result bundle between the EX controller and the multiply/divide unit.
// The controller drives Start/Op/A/B; the unit returns Busy and the HI/LO registers.
interface ex_mdu_if;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output Start, Op, A, B, input Busy, HI, LO);
   modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit holding HI/LO. The result is formed when the op is
// accepted and parked in a pending register until the fixed-latency run completes.
module ex_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic     Clk,
   input  logic     Reset,
   ex_mdu_if.slave  mdu
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        busy_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic [63:0] pend;
   logic        pend_wr;

   logic [63:0] calc;
   logic        calc_wr;

   function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
      logic signed [63:0] ax;
      logic signed [63:0] bx;
      ax = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      bx = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      return ax * bx;
   endfunction

   // Divides on magnitudes, then restores signs: quotient truncates toward zero and
   // the remainder follows the dividend. 0x80000000 / -1 falls out as {0, 0x80000000}.
   function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
      logic [31:0] ma;
      logic [31:0] mb;
      logic [31:0] q;
      logic [31:0] r;
      logic        neg_q;
      logic        neg_r;
      neg_r = sgn & a[31];
      neg_q = sgn & (a[31] ^ b[31]);
      ma    = neg_r ? -a : a;
      mb    = (sgn & b[31]) ? -b : b;
      q     = (mb == '0) ? '0 : ma / mb;
      r     = (mb == '0) ? '0 : ma % mb;
      return {(neg_r ? -r : r), (neg_q ? -q : q)};
   endfunction

   always_comb begin
      calc    = mdu.Op[1] ? div_full(mdu.A, mdu.B, ~mdu.Op[0])
                          : mul_full(mdu.A, mdu.B, ~mdu.Op[0]);
      calc_wr = ~(mdu.Op[1] & (mdu.B == '0));
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         busy_r  <= 1'b0;
         hi_r    <= '0;
         lo_r    <= '0;
         pend    <= '0;
         pend_wr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mdu.Start) begin
                  if (!mdu.Op[2]) begin
                     pend    <= calc;
                     pend_wr <= calc_wr;
                     cnt     <= mdu.Op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                     busy_r  <= 1'b1;
                     state   <= RUN;
                  end else if (mdu.Op == 3'd4) begin
                     hi_r <= mdu.A;
                  end else if (mdu.Op == 3'd5) begin
                     lo_r <= mdu.A;
                  end
               end
            end
            RUN: begin
               // Start is not looked at here: requests during a run are dropped.
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
                  if (pend_wr) begin
                     hi_r <= pend[63:32];
                     lo_r <= pend[31:0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mdu.Busy = busy_r;
   assign mdu.HI   = hi_r;
   assign mdu.LO   = lo_r;

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU.
- Takes the forwarded rs/rt operands (post-forwarding EX values) plus a decoded op from the EX controller.
- Holds the architectural HI/LO registers.
- Drives Busy to the conflict manager, which stalls any dependent mult/div/mf*/mt* in D while the unit is running.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (legal range 1..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  single-cycle request to begin the op on Op/A/B (mult, multu, div, divu, mthi, mtlo).
- Op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7 reserved.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- Busy  out  1  high while an operation is in flight.
- HI  out  32  registered HI.
- LO  out  32  registered LO.

Behaviour:
- Reset (Reset=0, asynchronous, at any time including mid-operation):
  - HI=0, LO=0, Busy=0.
  - Counter=0, state=IDLE.
  - Latched operands and pending result discarded.
- States: IDLE, RUN.
- IDLE, Start=1, Op in {0..3}:
  - Latch A, B, Op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; Busy=1 from the next cycle.
- IDLE, Start=1, Op=4 (mthi): HI<=A at this edge. Op=5 (mtlo): LO<=A at this edge. Stay IDLE, Busy stays 0.
- IDLE, Start=1, Op 6/7: ignored.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter goes 1->0: commit the result to HI/LO, Busy drops to 0, return to IDLE.
  - Start accepted at edge t gives Busy=1 for cycles t+1..t+N. New HI/LO are visible in cycle t+N+1, the same cycle Busy reads 0.
- Start while Busy=1: ignored entirely, including mthi/mtlo. The conflict manager guarantees this never happens; assertion only.
- Back-to-back: Start may be asserted in the first cycle Busy=0. It sees the freshly committed HI/LO.
- HI/LO only change on a commit or an mthi/mtlo edge; they hold while RUN.
- Arithmetic:
  - mult: 64-bit signed product, HI=[63:32], LO=[31:0]. multu: the same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend. divu: unsigned.
  - Divide by zero (B=0 at Start, div or divu): the run still takes DIV_CYCLES, but HI/LO stay unchanged at commit.
  - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- The result may be computed combinationally at latch time and held in a pending register, or iteratively, provided the commit timing above is exact.
- HI and LO read combinationally from registers; no bypass of an in-flight result.

Test Plan:
- Reset=0, then 1; Start=1, Op=0, A=0xFFFFFFFD, B=7 -> Busy=1 for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Op=1, A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. Then Op=3, A=7, B=2 issued in the first non-busy cycle -> 10 busy cycles, HI=1, LO=3.
- Op=2, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then Op=2, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload with mthi A=0x1234, then mtlo A=0x5678 (no Busy, HI/LO update at the next edge). Then Op=3, B=0 -> Busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- Start a mult; in busy cycle 2, pulse Start with Op=5, A=0xDEAD -> ignored, and the mult result commits on schedule.
- Start a div; drive Reset=0 asynchronously in busy cycle 4 -> Busy, HI and LO read 0 immediately. After release, a new mult runs the full 5 cycles.
